// File: rtl/io_timer.sv
// io_timer: memory-mapped down-counting timer with the intimer interrupt.
// Optional prescaler is built when TIMER_PRESCALE_EN is defined.
module io_timer #(
  parameter int         WIDTH    = 32,
  parameter logic [2:0] BASE_SEL = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        intimer
);

  localparam logic [2:0] R_CTRL   = 3'd0;
  localparam logic [2:0] R_LOAD   = 3'd1;
  localparam logic [2:0] R_COUNT  = 3'd2;
  localparam logic [2:0] R_STATUS = 3'd3;
  localparam logic [2:0] R_PRE    = 3'd4;

  logic             sel;
  logic             wr;
  logic [2:0]       idx;
  logic             wr_ctrl;
  logic             wr_load;
  logic             wr_count;
  logic             wr_status;
  logic [WIDTH-1:0] wdata;

  logic             en;
  logic             auto_rl;
  logic             ie;
  logic             pend;
  logic [WIDTH-1:0] load;
  logic [WIDTH-1:0] count;

  logic             tick;
  logic             count_zero;
  logic             expiry;

  logic             unused_bits;

  assign sel       = ce & (addr[7:5] == BASE_SEL);
  assign wr        = sel & we;
  assign idx       = addr[4:2];
  assign wr_ctrl   = wr & (idx == R_CTRL);
  assign wr_load   = wr & (idx == R_LOAD);
  assign wr_count  = wr & (idx == R_COUNT);
  assign wr_status = wr & (idx == R_STATUS);
  assign wdata     = dataIn[WIDTH-1:0];

  assign count_zero = (count == '0);
  assign expiry     = tick & count_zero;

  // Address and data bits outside the decoded fields are ignored.
  assign unused_bits = ^{addr[31:8], addr[1:0], dataIn};

`ifdef TIMER_PRESCALE_EN
  logic        wr_pre;
  logic        en_rise;
  logic [15:0] pre;
  logic [15:0] psc;

  assign wr_pre  = wr & (idx == R_PRE);
  assign en_rise = wr_ctrl & dataIn[0] & ~en;
  assign tick    = en & (psc == pre);

  // Prescale divisor register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else if (wr_pre) begin
      pre <= dataIn[15:0];
    end
  end

  // Prescale counter runs 0..PRE; restarts so the first tick lands PRE+1 cycles after enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc <= '0;
    end else if (!en || wr_pre || en_rise || tick) begin
      psc <= '0;
    end else begin
      psc <= psc + 16'd1;
    end
  end
`else
  assign tick = en;
`endif

  // Control bits; a CTRL write overrides the one-shot self-disable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
    end else if (wr_ctrl) begin
      en      <= dataIn[0];
      auto_rl <= dataIn[1];
      ie      <= dataIn[2];
    end else if (expiry && !auto_rl) begin
      en      <= 1'b0;
    end
  end

  // Reload value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load <= '0;
    end else if (wr_load) begin
      load <= wdata;
    end
  end

  // Down counter; a software write takes priority over the tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (wr_count) begin
      count <= wdata;
    end else if (tick) begin
      if (!count_zero) begin
        count <= count - WIDTH'(1);
      end else if (auto_rl) begin
        count <= load;
      end
    end
  end

  // Pending flag: expiry sets, write-1 clears, set beats clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 1'b0;
    end else if (expiry) begin
      pend <= 1'b1;
    end else if (wr_status && dataIn[0]) begin
      pend <= 1'b0;
    end
  end

  // Registered, maskable interrupt level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intimer <= 1'b0;
    end else begin
      intimer <= pend & ie;
    end
  end

  // Combinational read mux, zero when not selected.
  always_comb begin
    dataOut = '0;
    if (sel) begin
      case (idx)
        R_CTRL:   dataOut[2:0] = {ie, auto_rl, en};
        R_LOAD:   dataOut[WIDTH-1:0] = load;
        R_COUNT:  dataOut[WIDTH-1:0] = count;
        R_STATUS: dataOut[0] = pend;
`ifdef TIMER_PRESCALE_EN
        R_PRE:    dataOut[15:0] = pre;
`endif
        default:  dataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed scoreboard bench for io_timer.
// Prescaler checks follow TIMER_PRESCALE_EN.
module tb_io_timer;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        intimer;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  io_timer dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .we      (we),
    .addr    (addr),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .intimer (intimer)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    n_cmp++;
    assert (obs === e.val) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_raw(input logic c, input logic [31:0] a,
                        input logic [31:0] d);
    ce     = c;
    we     = 1'b1;
    addr   = a;
    dataIn = d;
    @(negedge clk);
    ce     = 1'b0;
    we     = 1'b0;
    dataIn = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_raw(1'b1, a, d);
  endtask

  task automatic rd_raw(input logic c, input logic [31:0] a,
                        input logic [31:0] v, input string tag);
    push(tag, v);
    ce   = c;
    we   = 1'b0;
    addr = a;
    #1;
    pop_cmp(dataOut);
    ce   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v,
                    input string tag);
    rd_raw(1'b1, a, v, tag);
  endtask

  task automatic chk_int(input logic v, input string tag);
    push(tag, {31'b0, v});
    pop_cmp({31'b0, intimer});
  endtask

  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_LOAD = 32'h04;
  localparam logic [31:0] A_CNT  = 32'h08;
  localparam logic [31:0] A_STAT = 32'h0C;
  localparam logic [31:0] A_PRE  = 32'h10;

  initial begin
    rst    = 1'b0;
    ce     = 1'b0;
    we     = 1'b0;
    addr   = '0;
    dataIn = '0;
    idle(3);
    rst = 1'b1;
    idle(1);

    rd(A_CTRL, 0, "rst_ctrl");
    rd(A_LOAD, 0, "rst_load");
    rd(A_CNT,  0, "rst_count");
    rd(A_STAT, 0, "rst_status");
    chk_int(1'b0, "rst_intimer");

    // one-shot, IE=1
    wr(A_CNT, 3);
    wr(A_CTRL, 32'h5);
    idle(3);
    rd(A_CNT,  0, "os_count_k3");
    rd(A_STAT, 0, "os_pend_k3");
    rd(A_CTRL, 5, "os_ctrl_k3");
    idle(1);
    rd(A_STAT, 1, "os_pend_k4");
    rd(A_CTRL, 4, "os_en_off");
    chk_int(1'b0, "os_int_k4");
    idle(1);
    chk_int(1'b1, "os_int_k5");

    // W1C on idle cycle
    wr(A_STAT, 1);
    rd(A_STAT, 0, "w1c_pend");
    chk_int(1'b1, "w1c_int_lag");
    idle(1);
    chk_int(1'b0, "w1c_int_drop");

    // auto-reload
    wr(A_LOAD, 2);
    wr(A_CNT, 2);
    wr(A_CTRL, 32'h7);
    rd(A_CNT, 2, "ar_c0");
    idle(1);
    rd(A_CNT, 1, "ar_c1");
    idle(1);
    rd(A_CNT, 0, "ar_c2");
    idle(1);
    rd(A_CNT, 2, "ar_c3");
    rd(A_STAT, 1, "ar_pend3");
    wr(A_STAT, 1);
    rd(A_STAT, 0, "ar_w1c");
    rd(A_CNT, 1, "ar_c4");
    chk_int(1'b1, "ar_int4");
    idle(1);
    rd(A_CNT, 0, "ar_c5");
    chk_int(1'b0, "ar_int5");
    wr(A_STAT, 1);
    rd(A_STAT, 1, "ar_set_wins");
    rd(A_CNT, 2, "ar_c6");
    wr(A_CTRL, 0);
    wr(A_STAT, 1);

    // IE=0 masking
    wr(A_CNT, 1);
    wr(A_CTRL, 1);
    idle(3);
    rd(A_STAT, 1, "mask_pend");
    rd(A_CTRL, 0, "mask_en_off");
    chk_int(1'b0, "mask_int");

    // decode
    wr_raw(1'b0, A_LOAD, 32'h55);
    rd(A_LOAD, 2, "dec_ce0_wr");
    wr(32'h24, 32'h66);
    rd(A_LOAD, 2, "dec_sel_wr");
    rd_raw(1'b0, A_LOAD, 0, "dec_ce0_rd");
    rd(32'h24, 0, "dec_sel_rd");
    rd(32'h14, 0, "dec_rsvd");

    wr(A_CNT, 32'hDEADBEEF);
    rd(A_CNT, 32'hDEADBEEF, "full_width");

    wr(A_STAT, 1);
`ifdef TIMER_PRESCALE_EN
    wr(A_PRE, 4);
    rd(A_PRE, 4, "pre_rd");
    wr(A_CNT, 1);
    wr(A_CTRL, 1);
    idle(4);
    rd(A_CNT, 1, "pre_c4");
    idle(1);
    rd(A_CNT, 0, "pre_c5");
    idle(4);
    rd(A_STAT, 0, "pre_pend9");
    idle(1);
    rd(A_STAT, 1, "pre_pend10");
`else
    wr(A_PRE, 4);
    rd(A_PRE, 0, "pre_absent");
`endif

    // reset mid-operation
    wr(A_CTRL, 0);
    wr(A_STAT, 1);
    wr(A_LOAD, 5);
    wr(A_CNT, 0);
    wr(A_CTRL, 32'h7);
    idle(3);
    chk_int(1'b1, "mr_int_pre");
    rst = 1'b0;
    #1;
    chk_int(1'b0, "mr_int");
    rd(A_CTRL, 0, "mr_ctrl");
    rd(A_LOAD, 0, "mr_load");
    rd(A_CNT,  0, "mr_count");
    rd(A_STAT, 0, "mr_status");
    idle(2);
    rst = 1'b1;
    idle(2);
    rd(A_CNT, 0, "mr_hold");
    chk_int(1'b0, "mr_int_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
